simple_fifo_16to32: RTL and testbench

Halfword-in, word-out synchronous FIFO. It accepts one 16-bit halfword per write and delivers one 32-bit word per read, formed from the two oldest halfwords. It is the width-converting counterpart of the team's 32-to-16 FIFO and sits on the narrow-to-wide side of the same datapath. A word split by the 32-to-16 FIFO and passed through this block comes out bit-identical. Status and acknowledge flags use the same format as the 32-to-16 FIFO, so control logic can drive either block.

---
 rtl/simple_fifo_16to32_if.sv | 27 ++
 rtl/simple_fifo_16to32.sv | 114 +++++++++++
 tb/tb_simple_fifo_16to32.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/simple_fifo_16to32_if.sv
// rtl/simple_fifo_16to32_if.sv - request/status bundle for the 16-to-32 width-converting FIFO
interface simple_fifo_16to32_if;
    logic        read;
    logic        write;
    logic [15:0] d_in;
    logic [31:0] d_out;
    logic        full;
    logic        empty;
    logic        word_avail;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;
    logic [4:0]  data_count;

    modport master (
        output read, write, d_in,
        input  d_out, full, empty, word_avail,
        input  wr_ack, wr_err, rd_ack, rd_err, data_count
    );

    modport slave (
        input  read, write, d_in,
        output d_out, full, empty, word_avail,
        output wr_ack, wr_err, rd_ack, rd_err, data_count
    );
endinterface

// File: rtl/simple_fifo_16to32.sv
// rtl/simple_fifo_16to32.sv - 16-entry halfword-in, word-out synchronous FIFO
module simple_fifo_16to32 (
    input  logic                 clk,
    input  logic                 rst_n,
    simple_fifo_16to32_if.slave  bus
);

    typedef enum logic [2:0] {
        INIT     = 3'b000,
        NO_OP    = 3'b001,
        READ     = 3'b010,
        RD_ERROR = 3'b011,
        WRITE    = 3'b100,
        WR_ERROR = 3'b101
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] mem [0:15];
    logic [3:0]  head;
    logic [3:0]  head_p1;
    logic [3:0]  tail;
    logic [4:0]  data_count;
    logic        is_full;
    logic        has_word;
    logic        do_write;
    logic        do_read;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;

    assign is_full  = (data_count == 5'd16);
    assign has_word = (data_count >= 5'd2);
    assign head_p1  = head + 4'd1;

    // Decode the request pair against the current fill level; 11 is a deliberate NOP.
    always_comb begin
        next_state = NO_OP;
        do_write   = 1'b0;
        do_read    = 1'b0;
        case ({bus.read, bus.write})
            2'b01: begin
                if (is_full) begin
                    next_state = WR_ERROR;
                end else begin
                    next_state = WRITE;
                    do_write   = 1'b1;
                end
            end
            2'b10: begin
                if (has_word) begin
                    next_state = READ;
                    do_read    = 1'b1;
                end else begin
                    next_state = RD_ERROR;
                end
            end
            default: next_state = NO_OP;
        endcase
    end

    // State register, pointers and fill count; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            head       <= 4'd0;
            tail       <= 4'd0;
            data_count <= 5'd0;
        end else begin
            state <= next_state;
            if (do_write) begin
                tail       <= tail + 4'd1;
                data_count <= data_count + 5'd1;
            end else if (do_read) begin
                head       <= head + 4'd2;
                data_count <= data_count - 5'd2;
            end
        end
    end

    // Halfword storage is not reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[tail] <= bus.d_in;
        end
    end

    // Ack/err flags report the previous edge's outcome, so they decode from the registered state.
    always_comb begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
        case (state)
            WRITE:    wr_ack = 1'b1;
            WR_ERROR: wr_err = 1'b1;
            READ:     rd_ack = 1'b1;
            RD_ERROR: rd_err = 1'b1;
            default: ;
        endcase
    end

    assign bus.d_out      = {mem[head], mem[head_p1]};
    assign bus.full       = is_full;
    assign bus.empty      = (data_count == 5'd0);
    assign bus.word_avail = has_word;
    assign bus.data_count = data_count;
    assign bus.wr_ack     = wr_ack;
    assign bus.wr_err     = wr_err;
    assign bus.rd_ack     = rd_ack;
    assign bus.rd_err     = rd_err;

endmodule

// File: tb/tb_simple_fifo_16to32.sv
// tb/tb_simple_fifo_16to32.sv - self-checking bench for the 16-to-32 FIFO
module tb_simple_fifo_16to32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    simple_fifo_16to32_if bus ();

    simple_fifo_16to32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] model [$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] din;
        logic [3:0]  flags;
        int          count;
        logic        chk_dout;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] cur_flags();
        return {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err};
    endfunction

    task automatic check_status(input string tag, input logic [3:0] ef, input int ec);
        check({tag, " flags"}, {28'd0, cur_flags()}, {28'd0, ef});
        check({tag, " count"}, {27'd0, bus.data_count}, ec);
        check({tag, " full"}, {31'd0, bus.full}, {31'd0, ec == 16});
        check({tag, " empty"}, {31'd0, bus.empty}, {31'd0, ec == 0});
        check({tag, " word_avail"}, {31'd0, bus.word_avail}, {31'd0, ec >= 2});
    endtask

    // One request per clock, predicted by the halfword queue model.
    task automatic op(input string tag, input logic r, input logic w, input logic [15:0] d);
        logic [3:0] ef;
        logic [31:0] exp_word;
        @(negedge clk);
        bus.read  = r;
        bus.write = w;
        bus.d_in  = d;
        ef = 4'b0000;
        if (r && !w) begin
            if (model.size() >= 2) begin
                exp_word = {model[0], model[1]};
                check({tag, " d_out"}, bus.d_out, exp_word);
                void'(model.pop_front());
                void'(model.pop_front());
                ef = 4'b0010;
            end else begin
                ef = 4'b0001;
            end
        end else if (w && !r) begin
            if (model.size() < 16) begin
                model.push_back(d);
                ef = 4'b1000;
            end else begin
                ef = 4'b0100;
            end
        end
        @(posedge clk);
        #1;
        check_status(tag, ef, model.size());
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{1'b0, 1'b1, 16'h1111, 4'b1000, 1, 1'b0, 32'h0},
            '{1'b0, 1'b1, 16'h2222, 4'b1000, 2, 1'b1, 32'h11112222},
            '{1'b1, 1'b0, 16'h0000, 4'b0010, 0, 1'b0, 32'h0},
            '{1'b1, 1'b0, 16'h0000, 4'b0001, 0, 1'b0, 32'h0},
            '{1'b0, 1'b1, 16'hABCD, 4'b1000, 1, 1'b0, 32'h0},
            '{1'b1, 1'b0, 16'h0000, 4'b0001, 1, 1'b0, 32'h0},
            '{1'b0, 1'b1, 16'h1234, 4'b1000, 2, 1'b1, 32'hABCD1234},
            '{1'b1, 1'b0, 16'h0000, 4'b0010, 0, 1'b0, 32'h0}
        };

        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.d_in  = 16'h0;
        rst_n     = 1'b0;
        #12;
        check_status("reset", 4'b0000, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic pair, empty read and odd-count read from the vector table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.read  = vecs[i].rd;
            bus.write = vecs[i].wr;
            bus.d_in  = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {28'd0, cur_flags()}, {28'd0, vecs[i].flags});
            check($sformatf("vec%0d", i), {27'd0, bus.data_count}, vecs[i].count);
            if (vecs[i].chk_dout) begin
                check($sformatf("vec%0d d_out", i), bus.d_out, vecs[i].dout);
            end
            bus.read  = 1'b0;
            bus.write = 1'b0;
        end
        op("idle", 1'b0, 1'b0, 16'h0);

        // Asynchronous reset in the middle of a stream.
        op("pre_rst", 1'b0, 1'b1, 16'h5555);
        op("pre_rst", 1'b0, 1'b1, 16'h6666);
        op("pre_rst", 1'b0, 1'b1, 16'h7777);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_status("mid_rst", 4'b0000, 0);
        model.delete();
        @(negedge clk);
        rst_n = 1'b1;
        op("post_rst", 1'b0, 1'b0, 16'h0);

        // Fill to 16, overflow, then drain in order.
        for (int i = 0; i < 16; i++) begin
            op("fill", 1'b0, 1'b1, 16'(i));
        end
        op("overflow", 1'b0, 1'b1, 16'hFFFF);
        op("full_hold", 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            op("drain", 1'b1, 1'b0, 16'h0);
        end
        op("underflow", 1'b1, 1'b0, 16'h0);

        // Wrap-around of both pointers.
        for (int i = 0; i < 14; i++) begin
            op("adv_w", 1'b0, 1'b1, 16'(16'h0100 + i));
        end
        for (int i = 0; i < 7; i++) begin
            op("adv_r", 1'b1, 1'b0, 16'h0);
        end
        op("wrap_w", 1'b0, 1'b1, 16'hAAAA);
        op("wrap_w", 1'b0, 1'b1, 16'hBBBB);
        op("wrap_w", 1'b0, 1'b1, 16'hCCCC);
        op("wrap_w", 1'b0, 1'b1, 16'hDDDD);
        op("wrap_r", 1'b1, 1'b0, 16'h0);
        op("wrap_r", 1'b1, 1'b0, 16'h0);

        // Simultaneous read and write is a NOP at data_count=4.
        op("sim_w", 1'b0, 1'b1, 16'h0A0A);
        op("sim_w", 1'b0, 1'b1, 16'h0B0B);
        op("sim_w", 1'b0, 1'b1, 16'h0C0C);
        op("sim_w", 1'b0, 1'b1, 16'h0D0D);
        op("sim_rw", 1'b1, 1'b1, 16'hEEEE);
        op("sim_rw", 1'b1, 1'b1, 16'hFFFF);
        op("sim_r", 1'b1, 1'b0, 16'h0);
        op("sim_r", 1'b1, 1'b0, 16'h0);
        op("sim_end", 1'b0, 1'b0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
